// File: rtl/sdram_block_requester.sv
// rtl/sdram_block_requester.sv - CPU word front end with a one-block write-through buffer over the SDRAM block req/ack interface
module sdram_block_requester #(
  parameter int BLOCK_BITS = 128,
  parameter int WORD_BITS  = 32,
  parameter int ADDR_BITS  = 26
) (
  input  logic                     iclk,
  input  logic                     ireset,
  input  logic                     ireq,
  input  logic                     iwe,
  input  logic [ADDR_BITS-1:0]     iaddr,
  input  logic [WORD_BITS-1:0]     iwdata,
  input  logic [WORD_BITS/8-1:0]   ibe,
  output logic [WORD_BITS-1:0]     ordata,
  output logic                     oack,
  output logic                     obusy,
  output logic                     owrite_req,
  output logic [ADDR_BITS-5:0]     owrite_address,
  output logic [BLOCK_BITS-1:0]    owrite_data,
  input  logic                     iwrite_ack,
  output logic                     oread_req,
  output logic [ADDR_BITS-5:0]     oread_address,
  input  logic [BLOCK_BITS-1:0]    iread_data,
  input  logic                     iread_ack,
  input  logic                     iin_use
);

  localparam int TAG_BITS = ADDR_BITS - 4;
  localparam int WORDS    = BLOCK_BITS / WORD_BITS;
  localparam int BYTES    = WORD_BITS / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_MERGE, S_WR_REQ, S_WR_WAIT, S_RESP, S_SETTLE
  } state_t;

  state_t                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [TAG_BITS-1:0]   tag_q, tag_d;
  logic [BLOCK_BITS-1:0] data_q, data_d;

  logic [TAG_BITS-1:0]   blk_addr;
  logic [1:0]            word_idx;
  logic                  hit;
  logic [WORD_BITS-1:0]  rd_word;
  logic [BLOCK_BITS-1:0] merged;
  logic                  unused_addr_bits;

  assign blk_addr         = iaddr[ADDR_BITS-1:4];
  assign word_idx         = iaddr[3:2];
  assign hit              = valid_q && (tag_q == blk_addr);
  assign unused_addr_bits = ^iaddr[1:0];

  always_comb begin
    rd_word = '0;
    merged  = data_q;
    for (int w = 0; w < WORDS; w++) begin
      if (word_idx == w[1:0]) begin
        rd_word = data_q[w*WORD_BITS +: WORD_BITS];
        for (int b = 0; b < BYTES; b++) begin
          if (ibe[b]) merged[w*WORD_BITS + b*8 +: 8] = iwdata[b*8 +: 8];
        end
      end
    end
  end

  // Addresses and write data are only driven while their request is in flight.
  assign obusy          = (state_q != S_IDLE);
  assign oread_address  = (state_q == S_RD_REQ || state_q == S_RD_WAIT) ? blk_addr : '0;
  assign owrite_address = (state_q == S_WR_REQ || state_q == S_WR_WAIT) ? tag_q : '0;
  assign owrite_data    = (state_q == S_WR_REQ || state_q == S_WR_WAIT) ? data_q : '0;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    oack       = 1'b0;
    ordata     = '0;
    oread_req  = 1'b0;
    owrite_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ireq) begin
          if (!iwe)           state_d = hit ? S_RESP : S_RD_REQ;
          else if (ibe == '0) state_d = S_RESP;
          else                state_d = hit ? S_MERGE : S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        oread_req = 1'b1;
        if (iin_use) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (iread_ack) begin
          data_d  = iread_data;
          tag_d   = blk_addr;
          valid_d = 1'b1;
          state_d = iwe ? S_MERGE : S_RESP;
        end
      end
      S_MERGE: begin
        data_d  = merged;
        state_d = S_WR_REQ;
      end
      S_WR_REQ: begin
        owrite_req = 1'b1;
        if (iin_use) state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (iwrite_ack) state_d = S_RESP;
      end
      S_RESP: begin
        oack    = 1'b1;
        ordata  = iwe ? '0 : rd_word;
        state_d = iin_use ? S_SETTLE : S_IDLE;
      end
      S_SETTLE: begin
        if (!iin_use) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

endmodule
